spi_slave: RTL and testbench
============================

# spi_slave

- SPI slave (target) endpoint for a single 8-bit full-duplex link, MSB first, with mode selected by CPOL/CPHA.
- SCLK, CS_N and MOSI are asynchronous to sys_clk. They are brought in through 2-flop synchronizers and oversampled.
- On the user side: a one-deep transmit buffer with a valid/ready handshake, and a single-cycle receive strobe.
- It sits at the pin boundary opposite an SPI master in the same design family and exchanges one byte per 8 SCLK cycles while CS_N is low.

## Interface
- CPOL, 0: idle level of spi_sclk.
- CPHA, 0: 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_reset_n  in  1  asynchronous, active-low reset.
- tx_data  in  8  byte to return to the master.
- tx_valid  in  1  tx_data is valid; accepted when tx_valid && tx_ready.
- tx_ready  out  1  transmit buffer is empty.
- rx_data  out  8  last complete byte received; held until the next byte completes.
- rx_valid  out  1  one-cycle strobe when rx_data updates.
- tx_underrun  out  1  one-cycle strobe when a byte load finds the buffer empty.
- busy  out  1  synchronized CS_N is active (low).
- spi_sclk  in  1  serial clock from the master.
- spi_cs_n  in  1  chip select, active low.
- spi_mosi  in  1  data from the master.
- spi_miso  out  1  data to the master.
- spi_miso_oe  out  1  tristate enable for spi_miso; high only while selected.

## Operation
- **Synchronizers:** spi_sclk, spi_cs_n and spi_mosi each pass through 2 flops. A third flop on sclk provides edge detection.
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other one.
- **States:**
  - IDLE: cs_sync high.
  - ACTIVE: cs_sync low.
  - IDLE -> ACTIVE on cs_sync falling; ACTIVE -> IDLE on cs_sync rising, from any bit position.
- **Receive:** on each sample edge in ACTIVE, rx_shift <= {rx_shift[6:0], mosi_sync} and the 3-bit bit_cnt increments.
  - When bit_cnt wraps 7 -> 0, rx_data <= completed byte and rx_valid pulses.
  - There is no backpressure. The consumer must take rx_data before the next byte completes.
- **Transmit:** tx_shift[7] drives spi_miso. A byte load copies the buffer into tx_shift and empties the buffer.
  - If the buffer is empty at load time, tx_shift <= 8'h00 and tx_underrun pulses.
  - CPHA=0: load on entry to ACTIVE and on each shift edge that completes a byte (8th trailing edge). Other shift edges do tx_shift <= {tx_shift[6:0], 1'b0}.
  - CPHA=1: load on the first shift (leading) edge of each byte (bit_cnt == 0). Later shift edges shift left.
- **Handshake:**
  - tx_ready = buffer empty.
  - A write and a load in the same cycle: the load uses the old buffer content (or 8'h00 plus underrun if empty), and the written byte is stored for the next load. There is no bypass.
- **CS_N deasserted mid-byte:** partial receive is discarded (no rx_valid), bit_cnt <= 0, spi_miso_oe <= 0. The buffer content is kept.
- **Outputs in IDLE:** spi_miso = 0 and spi_miso_oe = 0.

## Timing
- **Reset values:** tx_ready=1, rx_data=8'h00, rx_valid=0, tx_underrun=0, busy=0, spi_miso=0, spi_miso_oe=0. All shift registers, bit_cnt and the synchronizers are 0, except sclk sync flops = CPOL and cs sync flops = 1.
- **Reset asserted mid-transfer:** all of the above take effect immediately. Any buffered byte is lost.
- **Pin latency:** a pin change captured at sys_clk edge E0 is acted on at E3.
  - busy, spi_miso_oe and the CPHA=0 first load update at E3.
  - rx_valid is high from E3 to E4 after the 8th sample edge.
- **Protocol requirements:**
  - SCLK high and low phases each ≥ 4 sys_clk periods.
  - First SCLK edge ≥ 4 sys_clk periods after CS_N falls.
  - MOSI stable ≥ 3 sys_clk periods on both sides of the sample edge.
- **spi_miso timing:** updates at E3 of the shift edge. A tx_valid accepted at cycle N clears tx_ready at N+1.

## Test plan
- **Mode 0 exchange:** tx 8'hA5 queued, master sends 8'h3C. Expect rx_data=8'h3C with one rx_valid pulse, MISO bits 1,0,1,0,0,1,0,1, tx_ready high again after the load.
- **All four modes:** for each CPOL/CPHA, 8'h81 each way. Expect exact bit order and correct sample/shift edge alignment.
- **Back-to-back bytes:** refill the buffer after each load; 3 bytes 8'h01, 8'h02, 8'h03 without releasing CS_N. Expect 3 rx_valid pulses and no underrun.
- **Underrun:** no tx_valid before CS_N falls. Expect tx_underrun pulse and MISO=0 for the whole byte. A write during the same byte is returned in the next byte.
- **Abort:** CS_N rises after 5 bits. Expect no rx_valid and oe=0. The next frame receives 8'hF0 correctly from bit 0.
- **Async reset mid-byte:** all outputs return to their reset values, and a following transfer works normally.

Source files
------------

// File: rtl/spi_slave.sv
// SPI target endpoint: one 8-bit full-duplex byte per 8 SCLK cycles while CS_N is low.
// The pins are synchronized into sys_clk and every pin event is acted on three edges after capture.
module spi_slave #(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic       sys_clk,
  input  logic       sys_reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       busy,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe
);

  typedef enum logic [0:0] {IDLE, ACTIVE} state_t;

  state_t     state;
  logic       sclk_meta, sclk_sync, sclk_prev;
  logic       cs_meta, cs_sync, cs_prev;
  logic       mosi_meta, mosi_sync;
  logic       sample_stb, shift_stb;
  logic [7:0] rx_shift, tx_shift, tx_buf;
  logic [2:0] bit_cnt;

  logic       sclk_changed, lead_edge, trail_edge, sample_edge, shift_edge;
  logic       load, write;
  logic [7:0] load_byte, rx_next;

  // Edges are decoded one cycle after the synchronizer and registered as strobes,
  // which lines SCLK events up with CS_N events (both take effect three edges after capture).
  assign sclk_changed = sclk_sync != sclk_prev;
  assign lead_edge    = sclk_changed && (sclk_sync != CPOL);
  assign trail_edge   = sclk_changed && (sclk_sync == CPOL);
  assign sample_edge  = CPHA ? trail_edge : lead_edge;
  assign shift_edge   = CPHA ? lead_edge : trail_edge;

  assign write     = tx_valid && tx_ready;
  assign load_byte = tx_ready ? 8'h00 : tx_buf;
  assign rx_next   = {rx_shift[6:0], mosi_sync};

  // A byte load either enters ACTIVE (CPHA=0 only) or is the first shift edge of a byte.
  assign load = ((state == IDLE) && !cs_prev && (CPHA == 1'b0)) ||
                ((state == ACTIVE) && !cs_prev && shift_stb && (bit_cnt == 3'd0));

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state       <= IDLE;
      sclk_meta   <= CPOL;
      sclk_sync   <= CPOL;
      sclk_prev   <= CPOL;
      cs_meta     <= 1'b1;
      cs_sync     <= 1'b1;
      cs_prev     <= 1'b1;
      mosi_meta   <= 1'b0;
      mosi_sync   <= 1'b0;
      sample_stb  <= 1'b0;
      shift_stb   <= 1'b0;
      rx_shift    <= 8'h00;
      tx_shift    <= 8'h00;
      tx_buf      <= 8'h00;
      bit_cnt     <= 3'd0;
      tx_ready    <= 1'b1;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      busy        <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      sclk_meta  <= spi_sclk;
      sclk_sync  <= sclk_meta;
      sclk_prev  <= sclk_sync;
      cs_meta    <= spi_cs_n;
      cs_sync    <= cs_meta;
      cs_prev    <= cs_sync;
      mosi_meta  <= spi_mosi;
      mosi_sync  <= mosi_meta;
      sample_stb <= sample_edge;
      shift_stb  <= shift_edge;

      rx_valid    <= 1'b0;
      tx_underrun <= load && tx_ready;

      // Only an empty buffer accepts a write, so a same-cycle load always sees the old content.
      if (write) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end else if (load) begin
        tx_ready <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (!cs_prev) begin
            state       <= ACTIVE;
            busy        <= 1'b1;
            spi_miso_oe <= 1'b1;
            bit_cnt     <= 3'd0;
            rx_shift    <= 8'h00;
            if (CPHA == 1'b0) begin
              tx_shift <= load_byte;
              spi_miso <= load_byte[7];
            end else begin
              tx_shift <= 8'h00;
              spi_miso <= 1'b0;
            end
          end
        end
        ACTIVE: begin
          if (cs_prev) begin
            state       <= IDLE;
            busy        <= 1'b0;
            spi_miso_oe <= 1'b0;
            spi_miso    <= 1'b0;
            bit_cnt     <= 3'd0;
            rx_shift    <= 8'h00;
            tx_shift    <= 8'h00;
          end else begin
            if (sample_stb) begin
              rx_shift <= rx_next;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
              end
            end
            if (shift_stb) begin
              if (bit_cnt == 3'd0) begin
                tx_shift <= load_byte;
                spi_miso <= load_byte[7];
              end else begin
                tx_shift <= {tx_shift[6:0], 1'b0};
                spi_miso <= tx_shift[6];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: one instance per SPI mode (index = {CPOL, CPHA}),
// driven by a bit-banged master with a fixed SCLK half period.
module tb_spi_slave;

  localparam int HALF = 8;

  logic       sys_clk = 1'b0;
  logic       sys_reset_n;
  logic [7:0] tx_data;
  logic [3:0] tx_valid, tx_ready, rx_valid, tx_underrun, busy;
  logic [3:0] spi_sclk, spi_cs_n, spi_miso, spi_miso_oe;
  logic       spi_mosi;
  logic [7:0] rx_data [4];

  int n_checks = 0;
  int n_fails  = 0;
  int rxv_cnt [4] = '{default: 0};
  int unr_cnt [4] = '{default: 0};

  logic [7:0] feed_q [$];
  int         feed_sel;

  always #5 sys_clk = ~sys_clk;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      spi_slave #(.CPOL(1'(gi / 2)), .CPHA(1'(gi % 2))) u_dut (
        .sys_clk    (sys_clk),
        .sys_reset_n(sys_reset_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid[gi]),
        .tx_ready   (tx_ready[gi]),
        .rx_data    (rx_data[gi]),
        .rx_valid   (rx_valid[gi]),
        .tx_underrun(tx_underrun[gi]),
        .busy       (busy[gi]),
        .spi_sclk   (spi_sclk[gi]),
        .spi_cs_n   (spi_cs_n[gi]),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso[gi]),
        .spi_miso_oe(spi_miso_oe[gi])
      );
    end
  endgenerate

  // Pulse counters: a strobe held for more than one cycle shows up as an extra count.
  always @(negedge sys_clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rx_valid[k] === 1'b1)    rxv_cnt[k] <= rxv_cnt[k] + 1;
      if (tx_underrun[k] === 1'b1) unr_cnt[k] <= unr_cnt[k] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One negedge; also feeds the selected instance's buffer from feed_q.
  task automatic tick();
    @(negedge sys_clk);
    tx_valid = '0;
    if (feed_q.size() > 0 && tx_ready[feed_sel] === 1'b1 && sys_reset_n === 1'b1) begin
      tx_data            = feed_q.pop_front();
      tx_valid[feed_sel] = 1'b1;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic cs_low(input int m);
    spi_cs_n[m] = 1'b0;
    wait_cycles(HALF);
  endtask

  task automatic cs_high(input int m);
    wait_cycles(HALF);
    spi_cs_n[m] = 1'b1;
    wait_cycles(HALF);
  endtask

  task automatic xfer(input int m, input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    logic cpol, cpha;
    cpol = (m >= 2);
    cpha = (m % 2) == 1;
    mi   = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        spi_mosi = mo[7-i];
        wait_cycles(HALF);
        mi[7-i]     = spi_miso[m];
        spi_sclk[m] = !cpol;
        wait_cycles(HALF);
        spi_sclk[m] = cpol;
      end else begin
        spi_sclk[m] = !cpol;
        spi_mosi    = mo[7-i];
        wait_cycles(HALF);
        mi[7-i]     = spi_miso[m];
        spi_sclk[m] = cpol;
        wait_cycles(HALF);
      end
    end
  endtask

  initial begin
    logic [7:0] mi;
    int rv0, ur0;

    sys_reset_n = 1'b0;
    tx_data     = 8'h00;
    tx_valid    = '0;
    spi_sclk    = 4'b1100;
    spi_cs_n    = 4'hF;
    spi_mosi    = 1'b0;
    feed_sel    = 0;
    repeat (3) @(negedge sys_clk);
    sys_reset_n = 1'b1;
    wait_cycles(4);

    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_tx_ready%0d", k), 32'(tx_ready[k]), 32'd1);
      check($sformatf("rst_rx_data%0d", k), 32'(rx_data[k]), 32'h00);
      check($sformatf("rst_rx_valid%0d", k), 32'(rx_valid[k]), 32'd0);
      check($sformatf("rst_underrun%0d", k), 32'(tx_underrun[k]), 32'd0);
      check($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd0);
      check($sformatf("rst_miso%0d", k), 32'(spi_miso[k]), 32'd0);
      check($sformatf("rst_oe%0d", k), 32'(spi_miso_oe[k]), 32'd0);
    end

    // Mode 0 exchange with pin-latency checks on the CS_N fall.
    feed_sel = 0;
    feed_q.push_back(8'hA5);
    wait_cycles(3);
    check("m0_ready_after_write", 32'(tx_ready[0]), 32'd0);
    rv0 = rxv_cnt[0];
    spi_cs_n[0] = 1'b0;
    wait_cycles(3);
    check("m0_busy_before_e3", 32'(busy[0]), 32'd0);
    check("m0_miso_before_e3", 32'(spi_miso[0]), 32'd0);
    wait_cycles(1);
    check("m0_busy_at_e3", 32'(busy[0]), 32'd1);
    check("m0_oe_at_e3", 32'(spi_miso_oe[0]), 32'd1);
    check("m0_miso_at_e3", 32'(spi_miso[0]), 32'd1);
    check("m0_ready_after_load", 32'(tx_ready[0]), 32'd1);
    wait_cycles(HALF - 4);
    xfer(0, 8'h3C, 8, mi);
    check("m0_miso_byte", 32'(mi), 32'hA5);
    check("m0_rx_data", 32'(rx_data[0]), 32'h3C);
    cs_high(0);
    check("m0_rx_pulses", 32'(rxv_cnt[0] - rv0), 32'd1);
    check("m0_busy_after", 32'(busy[0]), 32'd0);
    check("m0_oe_after", 32'(spi_miso_oe[0]), 32'd0);
    check("m0_miso_after", 32'(spi_miso[0]), 32'd0);

    // All four modes, two bytes each way.
    for (int m = 0; m < 4; m++) begin
      feed_sel = m;
      feed_q.push_back(8'h81);
      feed_q.push_back(8'h2E);
      wait_cycles(3);
      rv0 = rxv_cnt[m];
      cs_low(m);
      check($sformatf("mode%0d_busy", m), 32'(busy[m]), 32'd1);
      xfer(m, 8'h81, 8, mi);
      check($sformatf("mode%0d_miso1", m), 32'(mi), 32'h81);
      check($sformatf("mode%0d_rx1", m), 32'(rx_data[m]), 32'h81);
      xfer(m, 8'h4B, 8, mi);
      check($sformatf("mode%0d_miso2", m), 32'(mi), 32'h2E);
      check($sformatf("mode%0d_rx2", m), 32'(rx_data[m]), 32'h4B);
      cs_high(m);
      check($sformatf("mode%0d_pulses", m), 32'(rxv_cnt[m] - rv0), 32'd2);
      check($sformatf("mode%0d_busy_off", m), 32'(busy[m]), 32'd0);
    end

    // Back-to-back bytes; a fourth byte covers the load at the end of byte 3.
    feed_sel = 0;
    for (int b = 1; b <= 4; b++) feed_q.push_back(8'(b));
    wait_cycles(3);
    rv0 = rxv_cnt[0];
    ur0 = unr_cnt[0];
    cs_low(0);
    for (int b = 1; b <= 3; b++) begin
      xfer(0, 8'(b), 8, mi);
      check($sformatf("b2b_miso%0d", b), 32'(mi), 32'(b));
      check($sformatf("b2b_rx%0d", b), 32'(rx_data[0]), 32'(b));
    end
    cs_high(0);
    check("b2b_pulses", 32'(rxv_cnt[0] - rv0), 32'd3);
    check("b2b_underruns", 32'(unr_cnt[0] - ur0), 32'd0);

    // Underrun at entry; a byte written mid-frame comes out in the next byte.
    rv0 = rxv_cnt[0];
    ur0 = unr_cnt[0];
    cs_low(0);
    check("unr_entry_pulse", 32'(unr_cnt[0] - ur0), 32'd1);
    feed_q.push_back(8'h5A);
    xfer(0, 8'h11, 8, mi);
    check("unr_miso1", 32'(mi), 32'h00);
    check("unr_rx1", 32'(rx_data[0]), 32'h11);
    xfer(0, 8'h22, 8, mi);
    check("unr_miso2", 32'(mi), 32'h5A);
    check("unr_rx2", 32'(rx_data[0]), 32'h22);
    cs_high(0);
    check("unr_total", 32'(unr_cnt[0] - ur0), 32'd2);
    check("unr_pulses", 32'(rxv_cnt[0] - rv0), 32'd2);

    // Abort after 5 bits, then a clean frame.
    rv0 = rxv_cnt[0];
    cs_low(0);
    xfer(0, 8'hFF, 5, mi);
    cs_high(0);
    check("abort_no_pulse", 32'(rxv_cnt[0] - rv0), 32'd0);
    check("abort_rx_held", 32'(rx_data[0]), 32'h22);
    check("abort_oe", 32'(spi_miso_oe[0]), 32'd0);
    check("abort_busy", 32'(busy[0]), 32'd0);
    cs_low(0);
    xfer(0, 8'hF0, 8, mi);
    cs_high(0);
    check("abort_next_rx", 32'(rx_data[0]), 32'hF0);
    check("abort_next_pulse", 32'(rxv_cnt[0] - rv0), 32'd1);

    // Asynchronous reset mid-byte with a full buffer.
    feed_q.push_back(8'h77);
    feed_q.push_back(8'hAA);
    wait_cycles(3);
    cs_low(0);
    xfer(0, 8'hFF, 4, mi);
    check("arst_buffer_full", 32'(tx_ready[0]), 32'd0);
    #3 sys_reset_n = 1'b0;
    #1;
    check("arst_tx_ready", 32'(tx_ready[0]), 32'd1);
    check("arst_busy", 32'(busy[0]), 32'd0);
    check("arst_oe", 32'(spi_miso_oe[0]), 32'd0);
    check("arst_miso", 32'(spi_miso[0]), 32'd0);
    check("arst_rx_data", 32'(rx_data[0]), 32'h00);
    check("arst_rx_valid", 32'(rx_valid[0]), 32'd0);
    check("arst_underrun", 32'(tx_underrun[0]), 32'd0);
    spi_cs_n = 4'hF;
    spi_sclk = 4'b1100;
    spi_mosi = 1'b0;
    wait_cycles(3);
    sys_reset_n = 1'b1;
    wait_cycles(4);
    feed_q.push_back(8'hC3);
    wait_cycles(3);
    rv0 = rxv_cnt[0];
    cs_low(0);
    xfer(0, 8'h96, 8, mi);
    check("post_rst_miso", 32'(mi), 32'hC3);
    check("post_rst_rx", 32'(rx_data[0]), 32'h96);
    cs_high(0);
    check("post_rst_pulse", 32'(rxv_cnt[0] - rv0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
